// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller.
//   SZ_*      : access size encodings on the size port (2'b11 is reserved).
//   state_e   : controller FSM states.
//   AW_DEF    : default word-address width of the data memory.
//   misaligned: 1 when size/offset cannot be served in one aligned word.
package lsu_pkg;
  localparam int AW_DEF = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store controller.
//   size_i/off_i/sext_i : access size, byte offset within word, sign-extend flag
//   ld_word_i -> ld_data_o : selected byte/half, right-justified and extended
//   st_word_i + wdata_i -> st_data_o : memory word with the addressed lane(s)
//                                      replaced by the store data
// Little-endian: byte k lives in bits 8k+7:8k.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        sext_i,
  input  logic [31:0] ld_word_i,
  input  logic [31:0] st_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign ld_b = ld_word_i[{off_i, 3'b000} +: 8];
  assign ld_h = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

  always_comb begin
    ld_data_o = ld_word_i;
    case (size_i)
      SZ_BYTE: ld_data_o = {{24{sext_i & ld_b[7]}}, ld_b};
      SZ_HALF: ld_data_o = {{16{sext_i & ld_h[15]}}, ld_h};
      default: ld_data_o = ld_word_i;
    endcase
  end

  always_comb begin
    st_data_o = st_word_i;
    case (size_i)
      SZ_BYTE: st_data_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (off_i[1]) st_data_o[31:16] = wdata_i[15:0];
        else          st_data_o[15:0]  = wdata_i[15:0];
      end
      default: st_data_o = wdata_i;
    endcase
  end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between a CPU and a single-port word memory.
//   CPU side : req/wr/size/sext/addr/wdata in; ready, done, err, rdata out.
//   Memory   : dm_addr/dm_din/dm_we out, dm_dout in (combinational read,
//              memory writes on negedge clk).
// Flow: IDLE -accept-> ACCESS [-> WRITE for sub-word stores] -> RESP -> IDLE.
// Misaligned requests go straight to RESP with err=1 and touch no memory.
// Sub-word stores are read-modify-write: the word is captured in ACCESS and
// the merged word is written in WRITE.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic          dm_we,
  input  logic [31:0]   dm_dout
);
  state_e        state_q;
  logic          wr_q;
  logic [1:0]    size_q;
  logic          sext_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem_q;     // word read in ACCESS for read-modify-write
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   ld_data;
  logic [31:0]   st_data;
  logic          word_st;

  // Upper address bits are outside the memory and intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  lsu_align u_align (
    .size_i    (size_q),
    .off_i     (addr_q[1:0]),
    .sext_i    (sext_q),
    .ld_word_i (dm_dout),
    .st_word_i (mem_q),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_data_o (st_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mem_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req) begin
          wr_q    <= wr;
          size_q  <= size;
          sext_q  <= sext;
          addr_q  <= addr[AW+1:0];
          wdata_q <= wdata;
          err_q   <= misaligned(size, addr[1:0]);
          state_q <= misaligned(size, addr[1:0]) ? S_RESP : S_ACCESS;
        end
        S_ACCESS: begin
          if (!wr_q) begin
            rdata_q <= ld_data;
            state_q <= S_RESP;
          end else if (size_q == SZ_WORD) begin
            state_q <= S_RESP;
          end else begin
            mem_q   <= dm_dout;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: state_q <= S_RESP;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Memory strobes decode from registered state only, so reset drops dm_we
  // asynchronously and no CPU input can glitch it.
  assign word_st = (state_q == S_ACCESS) && wr_q && (size_q == SZ_WORD);
  assign dm_we   = word_st || (state_q == S_WRITE);
  assign dm_din  = (state_q == S_WRITE) ? st_data : (word_st ? wdata_q : 32'h0);
  assign dm_addr = ((state_q == S_ACCESS) || (state_q == S_WRITE)) ? addr_q[AW+1:2] : '0;

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_RESP);
  assign err   = done && err_q;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req, wr, sext;
  logic [1:0]    size;
  logic [31:0]   addr, wdata;
  logic          ready, done, err, dm_we;
  logic [31:0]   rdata, dm_din, dm_dout;
  logic [AW-1:0] dm_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0]   mem [0:1023];
  int            we_cnt;
  logic [AW-1:0] we_addr;
  logic [31:0]   we_din;

  always #5 clk = ~clk;

  lsu_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
    .dm_dout(dm_dout)
  );

  // Data memory model: combinational read, write on negedge.
  assign dm_dout = mem[dm_addr];
  always @(negedge clk) begin
    if (dm_we) begin
      mem[dm_addr] = dm_din;
      we_cnt  = we_cnt + 1;
      we_addr = dm_addr;
      we_din  = dm_din;
    end
  end

  // Issue one request; returns edges from accept to done (1 = done right after accept).
  task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin @(negedge clk); guard++; end
    req = 1'b1; wr = w; size = sz; sext = sx; addr = a; wdata = d;
    we_cnt = 0;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    checks++;
    if ({ready, done, err, dm_we} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctl got %b exp 1000", {ready, done, err, dm_we});
    end
    checks++;
    if (rdata !== 32'h0 || dm_din !== 32'h0 || dm_addr !== '0) begin
      errors++; $display("FAIL reset_data got rdata=%h din=%h addr=%h exp 0", rdata, dm_din, dm_addr);
    end
  endtask

  task automatic test_word();
    int lat;
    do_op(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, lat);
    checks++;
    if (lat !== 2 || err !== 1'b0) begin errors++; $display("FAIL wst_lat got %0d err=%b exp 2 err=0", lat, err); end
    checks++;
    if (we_cnt !== 1 || we_addr !== 10'd4 || we_din !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wst_we got cnt=%0d addr=%0d din=%h exp 1 4 deadbeef", we_cnt, we_addr, we_din);
    end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL wst_rdata got %h exp 0", rdata); end
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, lat);
    checks++;
    if (lat !== 2 || rdata !== 32'hDEADBEEF || we_cnt !== 0) begin
      errors++; $display("FAIL wld got lat=%0d rdata=%h we=%0d exp 2 deadbeef 0", lat, rdata, we_cnt);
    end
  endtask

  task automatic test_sub_store();
    int lat;
    mem[4] = 32'h1122_3344;
    do_op(1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'h0000_00AB, lat);
    checks++;
    if (lat !== 3 || err !== 1'b0) begin errors++; $display("FAIL bst_lat got %0d err=%b exp 3 err=0", lat, err); end
    checks++;
    if (we_cnt !== 1 || we_din !== 32'h11AB3344 || mem[4] !== 32'h11AB3344) begin
      errors++; $display("FAIL bst_data got cnt=%0d din=%h mem=%h exp 1 11ab3344", we_cnt, we_din, mem[4]);
    end
    do_op(1'b1, 2'b01, 1'b0, 32'h0000_0010, 32'hFFFF_5566, lat);
    checks++;
    if (lat !== 3 || mem[4] !== 32'h11AB5566) begin
      errors++; $display("FAIL hst got lat=%0d mem=%h exp 3 11ab5566", lat, mem[4]);
    end
  endtask

  task automatic test_loads();
    int lat;
    mem[4] = 32'h8000_F0FF;
    do_op(1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0, lat);
    checks++;
    if (lat !== 2 || rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_s0 got %h lat=%0d exp ffffffff 2", rdata, lat); end
    do_op(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0, lat);
    checks++;
    if (rdata !== 32'h0000_00F0) begin errors++; $display("FAIL lbu_1 got %h exp 000000f0", rdata); end
    do_op(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, lat);
    checks++;
    if (rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_3 got %h exp ffffff80", rdata); end
    do_op(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, lat);
    checks++;
    if (rdata !== 32'h0000_8000) begin errors++; $display("FAIL lhu_2 got %h exp 00008000", rdata); end
    do_op(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, lat);
    checks++;
    if (rdata !== 32'hFFFF_8000) begin errors++; $display("FAIL lh_2 got %h exp ffff8000", rdata); end
    // Upper address bits beyond the memory must be ignored.
    do_op(1'b0, 2'b10, 1'b0, 32'hF000_1010, 32'h0, lat);
    checks++;
    if (rdata !== 32'h8000_F0FF) begin errors++; $display("FAIL lw_hi got %h exp 8000f0ff", rdata); end
  endtask

  task automatic test_misaligned();
    int lat;
    logic [31:0] r0;
    r0 = rdata;
    do_op(1'b1, 2'b01, 1'b0, 32'h0000_0013, 32'h0000_1234, lat);
    checks++;
    if (lat !== 1 || err !== 1'b1 || we_cnt !== 0 || rdata !== r0) begin
      errors++; $display("FAIL mis_hst got lat=%0d err=%b we=%0d rdata=%h exp 1 1 0 %h", lat, err, we_cnt, rdata, r0);
    end
    do_op(1'b0, 2'b10, 1'b0, 32'h0000_0016, 32'h0, lat);
    checks++;
    if (lat !== 1 || err !== 1'b1 || we_cnt !== 0 || rdata !== r0) begin
      errors++; $display("FAIL mis_wld got lat=%0d err=%b we=%0d rdata=%h exp 1 1 0 %h", lat, err, we_cnt, rdata, r0);
    end
    do_op(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h0, lat);
    checks++;
    if (lat !== 1 || err !== 1'b1 || we_cnt !== 0) begin
      errors++; $display("FAIL mis_sz3 got lat=%0d err=%b we=%0d exp 1 1 0", lat, err, we_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL err_pulse got err=%b done=%b exp 0 0", err, done); end
  endtask

  task automatic test_reset_write();
    int guard = 0;
    logic seen_done = 1'b0;
    mem[5] = 32'hCAFE_BABE;
    @(negedge clk);
    while (!ready && guard < 20) begin @(negedge clk); guard++; end
    req = 1'b1; wr = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h0000_0014; wdata = 32'h55;
    we_cnt = 0;
    @(posedge clk); #1; req = 1'b0;   // ACCESS
    @(posedge clk); #1;               // WRITE
    checks++;
    if (dm_we !== 1'b1) begin errors++; $display("FAIL rw_pre got dm_we=%b exp 1", dm_we); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dm_we !== 1'b0 || ready !== 1'b1 || done !== 1'b0 || dm_din !== 32'h0) begin
      errors++; $display("FAIL rw_rst got we=%b rdy=%b done=%b din=%h exp 0 1 0 0", dm_we, ready, done, dm_din);
    end
    @(negedge clk); #1;
    checks++;
    if (mem[5] !== 32'hCAFE_BABE || we_cnt !== 0) begin
      errors++; $display("FAIL rw_mem got %h we=%0d exp cafebabe 0", mem[5], we_cnt);
    end
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (done) seen_done = 1'b1; end
    checks++;
    if (seen_done !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL rw_nodone got done=%b rdy=%b exp 0 1", seen_done, ready);
    end
  endtask

  task automatic test_back_to_back();
    logic        o_wr [6];
    logic [1:0]  o_sz [6];
    logic [31:0] o_ad [6];
    logic [31:0] o_wd [6];
    logic [31:0] o_rd [6];
    int          exp_acc [6];
    int          acc_cyc [6];
    int acc_cnt = 0, done_cnt = 0, cyc = 0;
    logic was_ready;
    o_wr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    o_sz = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10};
    o_ad = '{32'h20, 32'h20, 32'h21, 32'h20, 32'h22, 32'h20};
    o_wd = '{32'h01020304, 32'h0, 32'hFF, 32'h0, 32'hBEEF, 32'h0};
    o_rd = '{32'h0, 32'h01020304, 32'h0, 32'h0102FF04, 32'h0, 32'hBEEFFF04};
    exp_acc = '{0, 3, 6, 10, 13, 17};
    @(negedge clk);
    req = 1'b1; wr = o_wr[0]; size = o_sz[0]; sext = 1'b0; addr = o_ad[0]; wdata = o_wd[0];
    while (done_cnt < 6 && cyc < 100) begin
      was_ready = ready;
      @(posedge clk); #1;
      if (was_ready && acc_cnt < 6) begin acc_cyc[acc_cnt] = cyc; acc_cnt++; end
      if (done) begin
        if (!o_wr[done_cnt]) begin
          checks++;
          if (rdata !== o_rd[done_cnt]) begin
            errors++; $display("FAIL b2b_rd%0d got %h exp %h", done_cnt, rdata, o_rd[done_cnt]);
          end
        end
        done_cnt++;
      end
      cyc++;
      @(negedge clk);
      if (acc_cnt < 6) begin
        wr = o_wr[acc_cnt]; size = o_sz[acc_cnt]; addr = o_ad[acc_cnt]; wdata = o_wd[acc_cnt];
      end else req = 1'b0;
    end
    req = 1'b0;
    checks++;
    if (acc_cnt !== 6 || done_cnt !== 6) begin
      errors++; $display("FAIL b2b_cnt got acc=%0d done=%0d exp 6 6", acc_cnt, done_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i < acc_cnt && acc_cyc[i] !== exp_acc[i]) begin
        errors++; $display("FAIL b2b_acc%0d got cycle %0d exp %0d", i, acc_cyc[i], exp_acc[i]);
      end
    end
    checks++;
    if (mem[8] !== 32'hBEEFFF04) begin errors++; $display("FAIL b2b_mem got %h exp beefff04", mem[8]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    we_cnt = 0; we_addr = '0; we_din = '0;
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0; addr = 32'h0; wdata = 32'h0;
    #12;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_word();
    test_sub_store();
    test_loads();
    test_misaligned();
    test_reset_write();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: AW, default 10, word-address width presented to data memory (1024 words).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req  input  1  CPU access request; sampled only while ready=1.
REQ-005 Port: wr  input  1  1=store, 0=load.
REQ-006 Port: size  input  2  00=byte, 01=half, 10=word; 11 reserved, treated as misaligned.
REQ-007 Port: sext  input  1  loads: 1=sign-extend, 0=zero-extend; ignored for stores and words.
REQ-008 Port: addr  input  32  byte address; only addr[AW+1:0] used, upper bits ignored.
REQ-009 Port: wdata  input  32  store data, right-justified for byte/half.
REQ-010 Port: ready  output  1  high only in IDLE; request accepted when req&ready.
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: err  output  1  valid with done; 1=misaligned, access suppressed.
REQ-013 Port: rdata  output  32  load result; valid with done, held until next done.
REQ-014 Port: dm_addr  output  AW  word address to data memory.
REQ-015 Port: dm_din  output  32  write word to data memory.
REQ-016 Port: dm_we  output  1  memory write enable; memory writes on negedge clk.
REQ-017 Port: dm_dout  input  32  combinational read word from data memory.

Function
REQ-018 States SHALL be IDLE, ACCESS, WRITE, RESP; dm_we SHALL decode from state only (glitch-free, no input path).
REQ-019 On accept in IDLE, addr/wr/size/sext/wdata SHALL be registered; misaligned (half & addr[0], word & addr[1:0]!=0, size=11) -> RESP with err=1, no memory access.
REQ-020 Aligned accept -> ACCESS; dm_addr = registered addr[AW+1:2] in ACCESS and WRITE.
REQ-021 ACCESS, load: dm_dout captured at cycle end; byte lane k=addr[1:0] (little-endian, byte k = bits 8k+7:8k), half lane addr[1]; extended per sext; -> RESP.
REQ-022 ACCESS, word store: dm_we=1, dm_din=wdata; -> RESP.
REQ-023 ACCESS, byte/half store: dm_we=0, dm_dout captured; -> WRITE; WRITE: dm_we=1, dm_din = captured word with selected lane(s) replaced by wdata[7:0]/[15:0]; -> RESP.
REQ-024 RESP: done=1 one cycle, err valid; -> IDLE. Latency accept->done: error 1 cycle, load/word store 2, sub-word store 3.
REQ-025 req while ready=0 SHALL be ignored; no queuing; back-to-back accepts possible every (latency+1) cycles.
REQ-026 dm_we SHALL be 0 in IDLE and RESP; at most one write per request.
REQ-027 err=0 and rdata unchanged on store completion.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, ready=1, done=0, err=0, rdata=0, dm_we=0, dm_addr=0, dm_din=0, regardless of state.
REQ-029 Reset during WRITE SHALL drop dm_we before the negedge when asserted before it; in-flight request discarded, no done.

Structure
REQ-030 Shared package lsu_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, AW default.
REQ-031 One combinational sub-module lsu_align: lane select/extend for loads and lane merge for stores.

Verification
REQ-032 Word store addr=0x0000_0010, wdata=0xDEADBEEF -> dm_we one cycle, dm_addr=4, done 2 cycles after accept, err=0; word load same addr -> rdata=0xDEADBEEF.
REQ-033 Word 4 =0x11223344; byte store addr=0x12, wdata=0xAB -> ACCESS read then WRITE dm_din=0x11AB3344, done at +3.
REQ-034 Word 4 =0x8000_F0FF; byte load addr=0x10 sext=1 -> 0xFFFFFFFF; half load addr=0x12 sext=0 -> 0x00008000; sext=1 -> 0xFFFF8000.
REQ-035 Half store addr=0x13 and word load addr=0x16 -> done at +1 with err=1, dm_we never asserted, rdata unchanged.
REQ-036 Assert rst_n low during WRITE of a byte store -> dm_we=0 immediately, ready=1, no done, memory word unchanged.
REQ-037 req held high continuously with alternating loads/stores -> each accepted only when ready=1, one done per accepted request.
